// File: rtl/button_pkg.sv
// Shared constants, state encoding and parameter helpers for the push-button conditioner.
// Used by both builds; the BTN_AUTOREPEAT_EN option lives in the sub-module and top.
package button_pkg;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int NUM_BTN   = 4;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Whole milliseconds to clock cycles, never less than one cycle.
  function automatic int ms_to_cycles(input int hz, input int ms);
    int c;
    c = (hz / 1000) * ms;
    return (c < 1) ? 1 : c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int db, input int rd, input int rr);
    int w;
    w = $clog2(max3(db, rd, rr) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One key: synchroniser, four-state debounce FSM with saturating window counter and,
// when BTN_AUTOREPEAT_EN is defined, a hold-repeat counter that adds extra press events.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DB_CYCLES   = 1,
  parameter int CNT_W       = 1,
  parameter int SYNC_STAGES = 2
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int RD_CYCLES   = 1,
  parameter int RR_CYCLES   = 1
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_n_i,
  output logic level_o,
  output logic press_evt_o
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_N-1:0] sync_q, sync_d;
  btn_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              evt_q, evt_d;
  logic              db_evt;
  logic              rep_evt;
  logic              s;

  // Flops reset to 1 so a key held through reset looks released until resampled.
  assign sync_d = {sync_q[SYNC_N-2:0], key_n_i};
  assign s      = ~sync_q[SYNC_N-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_evt  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (s) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!s) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_HELD;
          cnt_d   = '0;
          db_evt  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (s) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = ST_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_LAST = CNT_W'(RR_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;

  // Runs only while HELD stays HELD; RELEASE_WAIT freezes it, a full release clears it.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_evt     = 1'b0;
    if (state_q == ST_PRESS_WAIT && state_d == ST_HELD) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (state_q == ST_RELEASE_WAIT && state_d == ST_RELEASED) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b0;
    end else if (state_q == ST_HELD && s) begin
      if (rep_cnt_q == (rep_first_q ? RR_LAST : RD_LAST)) begin
        rep_evt     = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end else if (rep_cnt_q != CNT_MAX) begin
        rep_cnt_d = rep_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end
`else
  assign rep_evt = 1'b0;
`endif

  assign evt_d = db_evt | rep_evt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      evt_q   <= evt_d;
    end
  end

  assign level_o     = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
  assign press_evt_o = evt_q;

endmodule

// File: rtl/button_conditioner.sv
// Four-key conditioner for the HPS button PIOs: per-key debounce, up/down and left/right
// lockout, registered levels and press pulses. Define BTN_AUTOREPEAT_EN for hold auto-repeat.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CLK_HZ          = 50_000_000,
  parameter int DEBOUNCE_MS     = 10,
  parameter int REPEAT_DELAY_MS = 400,
  parameter int REPEAT_RATE_MS  = 100,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [NUM_BTN-1:0]   key_n_raw,
  output logic [NUM_BTN-1:0]   btn_level,
  output logic [NUM_BTN-1:0]   btn_press
);

  localparam int DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int RD_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
  localparam int RR_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
  localparam int CNT_W     = cnt_width(DB_CYCLES, RD_CYCLES, RR_CYCLES);

  logic [NUM_BTN-1:0] ch_level;
  logic [NUM_BTN-1:0] ch_evt;
  logic [NUM_BTN-1:0] level_d, level_q;
  logic [NUM_BTN-1:0] press_d, press_q;
  logic               lock_ud;
  logic               lock_lr;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .RD_CYCLES   (RD_CYCLES),
      .RR_CYCLES   (RR_CYCLES)
`endif
    ) u_ch (
      .clk_i       (clk_clk),
      .rst_ni      (reset_reset_n),
      .key_n_i     (key_n_raw[gi]),
      .level_o     (ch_level[gi]),
      .press_evt_o (ch_evt[gi])
    );
  end

  // Opposing keys both down cancel each other; the survivor reappears as soon as its partner drops.
  assign lock_ud = ch_level[BTN_UP] & ch_level[BTN_DOWN];
  assign lock_lr = ch_level[BTN_LEFT] & ch_level[BTN_RIGHT];

  always_comb begin
    level_d = ch_level;
    press_d = ch_evt;
    if (lock_ud) begin
      level_d[BTN_UP]   = 1'b0;
      level_d[BTN_DOWN] = 1'b0;
      press_d[BTN_UP]   = 1'b0;
      press_d[BTN_DOWN] = 1'b0;
    end
    if (lock_lr) begin
      level_d[BTN_LEFT]  = 1'b0;
      level_d[BTN_RIGHT] = 1'b0;
      press_d[BTN_LEFT]  = 1'b0;
      press_d[BTN_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      level_q <= '0;
      press_q <= '0;
    end else begin
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign btn_level = level_q;
  assign btn_press = press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner; expectations follow BTN_AUTOREPEAT_EN when defined.
module tb_button_conditioner;

  localparam int CLK_HZ          = 1000;
  localparam int DEBOUNCE_MS     = 4;
  localparam int REPEAT_DELAY_MS = 10;
  localparam int REPEAT_RATE_MS  = 3;
  localparam int SYNC_STAGES     = 2;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [3:0] key_n_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_clk = ~clk_clk;

  button_conditioner #(
    .CLK_HZ          (CLK_HZ),
    .DEBOUNCE_MS     (DEBOUNCE_MS),
    .REPEAT_DELAY_MS (REPEAT_DELAY_MS),
    .REPEAT_RATE_MS  (REPEAT_RATE_MS),
    .SYNC_STAGES     (SYNC_STAGES)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .key_n_raw     (key_n_raw),
    .btn_level     (btn_level),
    .btn_press     (btn_press)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  // Advance n edges, OR-ing every sampled press pulse into acc.
  task automatic run(input int n, output logic [3:0] acc);
    acc = 4'b0000;
    repeat (n) begin
      @(posedge clk_clk);
      #1;
      acc = acc | btn_press;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] seen;
    logic [3:0] s2;
    logic [3:0] exp_p;

    // Reset state
    reset_reset_n = 1'b0;
    key_n_raw     = 4'hF;
    tick(2);
    chk("reset_level", btn_level, 4'b0000);
    chk("reset_press", btn_press, 4'b0000);
    reset_reset_n = 1'b1;
    tick(3);
    chk("idle_level", btn_level, 4'b0000);
    chk("idle_press", btn_press, 4'b0000);

    // Clean press and release on up
    key_n_raw[0] = 1'b0;
    tick(7);
    chk("up_edge6_level", btn_level, 4'b0000);
    chk("up_edge6_press", btn_press, 4'b0000);
    tick(1);
    chk("up_edge7_level", btn_level, 4'b0001);
    chk("up_edge7_press", btn_press, 4'b0001);
    tick(1);
    chk("up_edge8_press", btn_press, 4'b0000);
    chk("up_edge8_level", btn_level, 4'b0001);
    key_n_raw[0] = 1'b1;
    tick(7);
    chk("up_rel_edge6_level", btn_level, 4'b0001);
    tick(1);
    chk("up_rel_edge7_level", btn_level, 4'b0000);
    chk("up_rel_edge7_press", btn_press, 4'b0000);
    tick(3);

    // Bounce on left: low 3, high 1, low held
    key_n_raw[2] = 1'b0;
    run(3, seen);
    key_n_raw[2] = 1'b1;
    run(1, s2);
    seen = seen | s2;
    key_n_raw[2] = 1'b0;
    run(7, s2);
    seen = seen | s2;
    chk("bounce_no_early_press", seen, 4'b0000);
    chk("bounce_edge6_level", btn_level, 4'b0000);
    tick(1);
    chk("bounce_edge7_press", btn_press, 4'b0100);
    chk("bounce_edge7_level", btn_level, 4'b0100);
    tick(1);
    chk("bounce_single_pulse", btn_press, 4'b0000);
    key_n_raw[2] = 1'b1;
    tick(10);
    chk("bounce_released", btn_level, 4'b0000);

    // Up/down lockout
    key_n_raw[0] = 1'b0;
    tick(8);
    chk("lock_up_level", btn_level, 4'b0001);
    tick(2);
    key_n_raw[1] = 1'b0;
    run(7, seen);
    chk("lock_before_level", btn_level, 4'b0001);
    run(1, s2);
    seen = seen | s2;
    chk("lock_active_level", btn_level, 4'b0000);
    run(4, s2);
    seen = seen | s2;
    chk("lock_no_down_press", {3'b000, seen[1]}, 4'b0000);
    chk("lock_hold_level", btn_level, 4'b0000);
    key_n_raw[0] = 1'b1;
    tick(7);
    chk("unlock_edge6_level", btn_level, 4'b0000);
    tick(1);
    chk("unlock_edge7_level", btn_level, 4'b0010);
    chk("unlock_edge7_press", btn_press, 4'b0000);
    key_n_raw[1] = 1'b1;
    tick(10);
    chk("lock_ud_released", btn_level, 4'b0000);

    // Left/right lockout
    key_n_raw[2] = 1'b0;
    tick(8);
    chk("lr_left_level", btn_level, 4'b0100);
    key_n_raw[3] = 1'b0;
    run(8, seen);
    chk("lr_locked_level", btn_level, 4'b0000);
    chk("lr_no_right_press", {seen[3], 3'b000}, 4'b0000);
    key_n_raw[3:2] = 2'b11;
    tick(10);
    chk("lr_released", btn_level, 4'b0000);

    // Reset mid-hold on right, key held through reset release
    key_n_raw[3] = 1'b0;
    tick(8);
    chk("rst_hold_level", btn_level, 4'b1000);
    chk("rst_hold_press", btn_press, 4'b1000);
    tick(3);
    reset_reset_n = 1'b0;
    #1;
    chk("rst_async_level", btn_level, 4'b0000);
    chk("rst_async_press", btn_press, 4'b0000);
    tick(2);
    chk("rst_held_level", btn_level, 4'b0000);
    reset_reset_n = 1'b1;
    run(7, seen);
    chk("rst_no_pulse", seen, 4'b0000);
    chk("rst_edge6_level", btn_level, 4'b0000);
    tick(1);
    chk("rst_repress_press", btn_press, 4'b1000);
    chk("rst_repress_level", btn_level, 4'b1000);

    // Continue holding right for 30 cycles after acceptance
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      exp_p = 4'b0000;
`ifdef BTN_AUTOREPEAT_EN
      if (k >= 10 && ((k - 10) % 3) == 0) exp_p = 4'b1000;
`endif
      chk($sformatf("repeat_k%0d", k), btn_press, exp_p);
    end
    chk("repeat_level", btn_level, 4'b1000);
    key_n_raw = 4'hF;
    tick(10);
    chk("repeat_released", btn_level, 4'b0000);

    // Independent channels pressed together
    key_n_raw = 4'b1010;
    tick(7);
    chk("indep_edge6_press", btn_press, 4'b0000);
    tick(1);
    chk("indep_edge7_press", btn_press, 4'b0101);
    chk("indep_edge7_level", btn_level, 4'b0101);
    tick(1);
    chk("indep_edge8_press", btn_press, 4'b0000);
    key_n_raw = 4'hF;
    tick(10);
    chk("indep_released", btn_level, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
